friscv_mc_core: RTL

Parametrised multi-cycle FRiscV core. It replaces the hard-wired single-cycle datapath with an FSM-sequenced datapath and one unified memory port that has a request/ready handshake, so wait-state memories are supported. Register width, register-file depth (RV32I/RV32E) and reset vector are all parametrised. The core sits between the top wrapper and a single shared instruction/data SRAM.

---
 rtl/friscv_mc_core_if.sv | 22 ++
 rtl/friscv_mc_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/friscv_mc_core_if.sv
// Unified instruction/data memory port of the multi-cycle FRiscV core.
// The core drives the request side; the SRAM answers with rdata/ready.
interface friscv_mc_core_if #(
   parameter int ARCH = 32
);
   logic            mem_req_out;
   logic            mem_we_out;
   logic [ARCH-1:0] mem_addr_out;
   logic [ARCH-1:0] mem_wdata_out;
   logic [ARCH-1:0] mem_rdata_in;
   logic            mem_ready_in;

   modport master (
      output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
      input  mem_rdata_in, mem_ready_in
   );

   modport slave (
      input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
      output mem_rdata_in, mem_ready_in
   );
endinterface

// File: rtl/friscv_mc_core.sv
// Multi-cycle FRiscV core: FSM-sequenced datapath, one shared memory port.
// Optional retired-instruction counter enabled by FRISCV_PERF_CNT_EN.
module friscv_mc_core #(
   parameter int              ARCH          = 32,
   parameter int              REGFILE_DEPTH = 32,
   parameter logic [ARCH-1:0] RESET_VECTOR  = '0
) (
   input  logic                clk,
   input  logic                rst,
   friscv_mc_core_if.master    mem,
   output logic                illegal_out,
   output logic [31:0]         instret_out
);
   localparam int IW = $clog2(REGFILE_DEPTH);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [ARCH-1:0] r_pc;
   logic [ARCH-1:0] r_pc_old;
   logic [ARCH-1:0] r_a;
   logic [ARCH-1:0] r_b;
   logic [ARCH-1:0] r_imm;
   logic [ARCH-1:0] r_alu;
   logic [ARCH-1:0] r_mdr;
   logic [31:0]     r_ir;
   logic            r_illegal;
   logic [ARCH-1:0] r_rf [REGFILE_DEPTH];

   logic [6:0]      w_op;
   logic [2:0]      w_f3;
   logic [6:0]      w_f7;
   logic [4:0]      w_rd;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic            w_is_lw;
   logic            w_is_sw;
   logic            w_is_addi;
   logic            w_is_r;
   logic            w_is_beq;
   logic            w_is_jal;
   logic            w_bad_idx;
   logic            w_legal;
   logic [ARCH-1:0] w_imm;
   logic [ARCH-1:0] w_addr;
   logic [ARCH-1:0] w_alu_res;
   logic [ARCH-1:0] w_slt;

   assign w_op  = r_ir[6:0];
   assign w_f3  = r_ir[14:12];
   assign w_f7  = r_ir[31:25];
   assign w_rd  = r_ir[11:7];
   assign w_rs1 = r_ir[19:15];
   assign w_rs2 = r_ir[24:20];

   assign w_is_lw   = (w_op == 7'h03) && (w_f3 == 3'b010);
   assign w_is_sw   = (w_op == 7'h23) && (w_f3 == 3'b010);
   assign w_is_addi = (w_op == 7'h13) && (w_f3 == 3'b000);
   assign w_is_beq  = (w_op == 7'h63) && (w_f3 == 3'b000);
   assign w_is_jal  = (w_op == 7'h6f);
   assign w_is_r    = (w_op == 7'h33) &&
                      (((w_f7 == 7'h00) && ((w_f3 == 3'b000) ||
                        (w_f3 == 3'b111) || (w_f3 == 3'b110) ||
                        (w_f3 == 3'b010))) ||
                       ((w_f7 == 7'h20) && (w_f3 == 3'b000)));

   assign w_legal = w_is_lw | w_is_sw | w_is_addi |
                    w_is_r | w_is_beq | w_is_jal;

   // Only the register fields an instruction actually uses are range-checked
   assign w_bad_idx =
      ((w_is_lw | w_is_sw | w_is_addi | w_is_r | w_is_beq) &&
       (32'(w_rs1) >= REGFILE_DEPTH)) ||
      ((w_is_sw | w_is_r | w_is_beq) &&
       (32'(w_rs2) >= REGFILE_DEPTH)) ||
      ((w_is_lw | w_is_addi | w_is_r | w_is_jal) &&
       (32'(w_rd) >= REGFILE_DEPTH));

   always_comb begin
      w_imm = {{(ARCH-12){r_ir[31]}}, r_ir[31:20]};
      if (w_is_sw)
         w_imm = {{(ARCH-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      else if (w_is_beq)
         w_imm = {{(ARCH-13){r_ir[31]}}, r_ir[31], r_ir[7],
                  r_ir[30:25], r_ir[11:8], 1'b0};
      else if (w_is_jal)
         w_imm = {{(ARCH-21){r_ir[31]}}, r_ir[31], r_ir[19:12],
                  r_ir[20], r_ir[30:21], 1'b0};
   end

   assign w_addr = r_a + r_imm;
   assign w_slt  = {{(ARCH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};

   always_comb begin
      w_alu_res = r_a + r_imm;
      if (w_is_r) begin
         case (w_f3)
            3'b000:  w_alu_res = w_f7[5] ? (r_a - r_b) : (r_a + r_b);
            3'b111:  w_alu_res = r_a & r_b;
            3'b110:  w_alu_res = r_a | r_b;
            default: w_alu_res = w_slt;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  if (mem.mem_ready_in) w_next = S_DECODE;
         S_DECODE: w_next = (w_legal && !w_bad_idx) ? S_EXEC : S_HALT;
         S_EXEC: begin
            if (w_is_lw || w_is_sw)
               w_next = (w_addr[1:0] != 2'b00) ? S_HALT : S_MEM;
            else if (w_is_beq)
               w_next = S_FETCH;
            else
               w_next = S_WB;
         end
         S_MEM:    if (mem.mem_ready_in)
                      w_next = w_is_sw ? S_FETCH : S_WB;
         S_WB:     w_next = S_FETCH;
         default:  w_next = S_HALT;
      endcase
   end

   // Bus outputs are forced idle while rst is high, even mid-handshake
   assign mem.mem_req_out   = !rst && ((r_state == S_FETCH) ||
                                       (r_state == S_MEM));
   assign mem.mem_we_out    = !rst && (r_state == S_MEM) && w_is_sw;
   assign mem.mem_addr_out  = rst ? '0 :
                              (r_state == S_FETCH) ? r_pc :
                              (r_state == S_MEM)   ? r_alu : '0;
   assign mem.mem_wdata_out = mem.mem_we_out ? r_b : '0;
   assign illegal_out       = r_illegal;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_pc      <= RESET_VECTOR;
         r_pc_old  <= '0;
         r_ir      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_imm     <= '0;
         r_alu     <= '0;
         r_mdr     <= '0;
         r_illegal <= 1'b0;
         for (int i = 0; i < REGFILE_DEPTH; i++) r_rf[i] <= '0;
      end else begin
         r_state <= w_next;
         if (w_next == S_HALT) r_illegal <= 1'b1;
         case (r_state)
            S_FETCH: if (mem.mem_ready_in) begin
               r_ir     <= mem.mem_rdata_in[31:0];
               r_pc_old <= r_pc;
               r_pc     <= r_pc + ARCH'(4);
            end
            S_DECODE: begin
               r_a   <= r_rf[w_rs1[IW-1:0]];
               r_b   <= r_rf[w_rs2[IW-1:0]];
               r_imm <= w_imm;
            end
            S_EXEC: begin
               if (w_is_beq) begin
                  if (r_a == r_b) r_pc <= r_pc_old + r_imm;
               end else if (w_is_jal) begin
                  r_alu <= r_pc_old + ARCH'(4);
                  r_pc  <= r_pc_old + r_imm;
               end else if (w_is_lw || w_is_sw) begin
                  r_alu <= w_addr;
               end else begin
                  r_alu <= w_alu_res;
               end
            end
            S_MEM: if (mem.mem_ready_in) r_mdr <= mem.mem_rdata_in;
            S_WB: if (w_rd != 5'd0)
               r_rf[w_rd[IW-1:0]] <= w_is_lw ? r_mdr : r_alu;
            default: ;
         endcase
      end
   end

`ifdef FRISCV_PERF_CNT_EN
   logic [31:0] r_instret;
   logic        w_retire;

   assign w_retire = (w_next == S_FETCH) &&
                     ((r_state == S_EXEC) || (r_state == S_MEM) ||
                      (r_state == S_WB));

   always_ff @(posedge clk) begin
      if (rst)           r_instret <= '0;
      else if (w_retire) r_instret <= r_instret + 32'd1;
   end

   assign instret_out = r_instret;
`else
   assign instret_out = '0;
`endif
endmodule
